mw_stage: RTL and testbench
===========================

# mw_stage

Memory-access stage plus MEM/WB pipeline register of the five-stage MIPS core. It consumes the M-stage signals from the EX/MEM register and performs word, half and byte stores into an internal data memory. It extracts and extends load data, selects the write-back value, and registers everything into W for the register file and the forwarding and hazard logic.

## Interface
- DEPTH, 3072, data-memory size in 32-bit words (0x0000–0x2FFF)
- AW, 12, word-index width; index = M_result[AW+1:2]

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- M_result  in  32  ALU result; byte address for loads and stores
- M_regwe  in  1  register write enable of the M instruction
- M_memse  in  1  store enable
- M_memop  in  3  access width: 0 word, 1 half unsigned, 2 half signed, 3 byte unsigned, 4 byte signed
- M_A3  in  5  destination register
- M_regwdop  in  2  write-back select: 0 M_result, 1 load data, 2 M_pc+8, 3 reserved (drives 0)
- M_rt  in  32  store data, already forwarded
- M_pc  in  32  PC of the M instruction
- M_Tnew  in  2  cycles until the M result is ready
- M_fwd  out  32  forwardable M value: M_result if regwdop=0, M_pc+8 if regwdop=2, otherwise 0
- W_regwd  out  32  registered write-back data
- W_regwe  out  1  registered write enable, forced 0 when W_A3=0
- W_A3  out  5  registered destination
- W_pc  out  32  registered PC
- W_Tnew  out  2  registered Tnew

## Operation
- Word index = M_result[13:2]. An index ≥ DEPTH is out of range: stores are dropped and loads return 0.
- Stores (M_memse=1) are written at posedge clk.
  - Word: full word, M_result[1:0] ignored.
  - Half (memop 1/2): M_rt[15:0] goes to halfword M_result[1]; M_result[0] is ignored.
  - Byte (memop 3/4): M_rt[7:0] goes to byte lane M_result[1:0].
  - Unwritten lanes keep their value.
- Loads read asynchronously from the current word.
  - Half: select lane M_result[1]; zero-extend (1) or sign-extend (2).
  - Byte: select lane M_result[1:0]; zero-extend (3) or sign-extend (4).
  - memop 5–7 behave as word.
- Write-back select follows M_regwdop. pc+8 is computed mod 2^32.
- W Tnew = M_Tnew−1, saturating at 0.
- W_regwe = M_regwe & (M_A3≠0), registered.
- Simulation-only: on every accepted store, print "@<M_pc hex>: *<byte addr, word-aligned, hex> <= <full resulting word hex>".

## Timing
- Reset (synchronous, active-high):
  - Outputs: W_regwd=0, W_regwe=0, W_A3=0, W_pc=0, W_Tnew=0.
  - Every memory word is cleared to 0 on the same edge.
  - A store presented during reset is dropped; reset wins.
- Latency:
  - Store is visible to a load one cycle later.
  - A load in the same cycle as a store reads the pre-store word.
  - Load data reaches W_regwd one edge after the load is in M.
- M_fwd is combinational, zero latency. Load data is never forwarded from M; the hazard unit stalls via Tnew.
- No stall or flush inputs. Bubbles arrive as M_regwe=0 / M_memse=0 from upstream.
- Reset asserted mid-stream discards the in-flight M instruction and all memory contents.

## Structure
- Shared package `mips_pkg`:
  - memop codes MEMOP_W, MEMOP_HU, MEMOP_H, MEMOP_BU, MEMOP_B
  - regwdop codes WD_ALU, WD_MEM, WD_PC8
  - DM_DEPTH
- One natural sub-module, `dm`: memory array, byte-lane write and store logging. It exposes the raw read word.
- Load extension, write-back select and the W register live in the top level.

## Test plan
- Reset, then lw from 0x0000 and 0x2FFC → W_regwd=0 for each; W_Tnew=0; W_regwe follows M_regwe.
- sw 0x12345678 at 0x10, then lw 0x10 with A3=8 → W_regwd=0x12345678, W_A3=8; log "@<pc>: *00000010 <= 12345678".
- Store bytes:
  - sb 0xAB at 0x13 onto a word of 0 → word 0xAB000000.
  - lb 0x13 → 0xFFFFFFAB; lbu → 0x000000AB.
  - sh 0x8001 at 0x12 → word 0x80010000; lh 0x12 → 0xFFFF8001.
- jal-type: regwdop=2, M_pc=0x3000, A3=31 → M_fwd=0x3008 in the same cycle and W_regwd=0x3008 next cycle.
- Write to $0 and Tnew:
  - M_regwe=1 with A3=0 → W_regwe=0.
  - M_Tnew=2 → W_Tnew=1; M_Tnew=0 → W_Tnew=0.
- Edge cases:
  - Store to 0x3000 (out of range) → no log and no change; a later lw there returns 0.
  - sw asserted together with reset → a lw of that address after reset returns 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline.
// Memory access codes, write-back selects, data memory geometry.
package mips_pkg;

  localparam int DM_DEPTH = 3072;
  localparam int DM_AW    = 12;

  typedef enum logic [2:0] {
    MEMOP_W  = 3'd0,
    MEMOP_HU = 3'd1,
    MEMOP_H  = 3'd2,
    MEMOP_BU = 3'd3,
    MEMOP_B  = 3'd4
  } memop_e;

  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_MEM = 2'd1,
    WD_PC8 = 2'd2
  } regwdop_e;

endpackage

// File: rtl/dm.sv
// Data memory: word array with byte-lane stores and store logging.
// Read is asynchronous and returns the raw word (0 when out of range).
module dm
  import mips_pkg::*;
#(
  parameter int DEPTH = DM_DEPTH,
  parameter int AW    = DM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [2:0]    memop,
  input  logic [AW+1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [31:0]   pc,
  output logic [31:0]   rdata
);

  localparam logic [AW:0] LIM = DEPTH[AW:0];

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          in_range;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   merged;

  assign idx      = addr[AW+1:2];
  assign in_range = {1'b0, idx} < LIM;
  assign rdata    = in_range ? mem[idx] : 32'd0;

  // Lane enables and replicated store data for the access width
  always_comb begin
    be = 4'hf;
    wd = wdata;
    case (memop)
      MEMOP_HU, MEMOP_H: begin
        be = addr[1] ? 4'hc : 4'h3;
        wd = {2{wdata[15:0]}};
      end
      MEMOP_BU, MEMOP_B: begin
        be = 4'b0001 << addr[1:0];
        wd = {4{wdata[7:0]}};
      end
      default: begin
        be = 4'hf;
        wd = wdata;
      end
    endcase
  end

  // Merge new lanes into the current word
  always_comb begin
    merged = rdata;
    for (int l = 0; l < 4; l++) begin
      if (be[l]) merged[8*l +: 8] = wd[8*l +: 8];
    end
  end

  // Memory array: cleared on reset, written on an accepted store
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && in_range) begin
      mem[idx] <= merged;
    end
  end

`ifndef SYNTHESIS
  // Store trace for simulation
  always @(posedge clk) begin
    if (!reset && we && in_range)
      $display("@%h: *%h <= %h", pc,
               {{(30-AW){1'b0}}, idx, 2'b00}, merged);
  end
`endif

endmodule

// File: rtl/mw_stage.sv
// Memory stage plus MEM/WB register.
// Extends load data, selects write-back value, registers W.
module mw_stage
  import mips_pkg::*;
#(
  parameter int DEPTH = DM_DEPTH,
  parameter int AW    = DM_AW
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_result,
  input  logic        M_regwe,
  input  logic        M_memse,
  input  logic [2:0]  M_memop,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  M_regwdop,
  input  logic [31:0] M_rt,
  input  logic [31:0] M_pc,
  input  logic [1:0]  M_Tnew,
  output logic [31:0] M_fwd,
  output logic [31:0] W_regwd,
  output logic        W_regwe,
  output logic [4:0]  W_A3,
  output logic [31:0] W_pc,
  output logic [1:0]  W_Tnew
);

  logic [31:0] rword;
  logic [31:0] ldata;
  logic [31:0] pc8;
  logic [31:0] wd;
  logic [15:0] hw;
  logic [7:0]  bt;
  logic [1:0]  tnew;

  dm #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_dm (
    .clk  (clk),
    .reset(reset),
    .we   (M_memse),
    .memop(M_memop),
    .addr (M_result[AW+1:0]),
    .wdata(M_rt),
    .pc   (M_pc),
    .rdata(rword)
  );

  assign pc8  = M_pc + 32'd8;
  assign hw   = M_result[1] ? rword[31:16] : rword[15:0];
  assign bt   = rword[{M_result[1:0], 3'b000} +: 8];
  assign tnew = (M_Tnew == 2'd0) ? 2'd0 : M_Tnew - 2'd1;

  // Load lane select and extension
  always_comb begin
    ldata = rword;
    case (M_memop)
      MEMOP_HU: ldata = {16'd0, hw};
      MEMOP_H:  ldata = {{16{hw[15]}}, hw};
      MEMOP_BU: ldata = {24'd0, bt};
      MEMOP_B:  ldata = {{24{bt[7]}}, bt};
      default:  ldata = rword;
    endcase
  end

  // Write-back value and forwardable value
  always_comb begin
    wd    = 32'd0;
    M_fwd = 32'd0;
    case (M_regwdop)
      WD_ALU: begin
        wd    = M_result;
        M_fwd = M_result;
      end
      WD_MEM: wd = ldata;
      WD_PC8: begin
        wd    = pc8;
        M_fwd = pc8;
      end
      default: begin
        wd    = 32'd0;
        M_fwd = 32'd0;
      end
    endcase
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      W_regwd <= '0;
      W_regwe <= 1'b0;
      W_A3    <= '0;
      W_pc    <= '0;
      W_Tnew  <= '0;
    end else begin
      W_regwd <= wd;
      W_regwe <= M_regwe & (M_A3 != 5'd0);
      W_A3    <= M_A3;
      W_pc    <= M_pc;
      W_Tnew  <= tnew;
    end
  end

endmodule

// File: tb/tb_mw_stage.sv
// Self-checking bench for mw_stage.
// Reference model: flat word array updated by address arithmetic.
module tb_mw_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] M_result = '0;
  logic        M_regwe = 1'b0;
  logic        M_memse = 1'b0;
  logic [2:0]  M_memop = '0;
  logic [4:0]  M_A3 = '0;
  logic [1:0]  M_regwdop = '0;
  logic [31:0] M_rt = '0;
  logic [31:0] M_pc = '0;
  logic [1:0]  M_Tnew = '0;
  logic [31:0] M_fwd;
  logic [31:0] W_regwd;
  logic        W_regwe;
  logic [4:0]  W_A3;
  logic [31:0] W_pc;
  logic [1:0]  W_Tnew;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mdl [0:3071];
  logic [31:0] exp_wd, exp_pc, exp_fwd, obs_fwd;
  logic        exp_we;
  logic [4:0]  exp_a3;
  logic [1:0]  exp_tn;

  mw_stage dut (
    .clk(clk), .reset(reset),
    .M_result(M_result), .M_regwe(M_regwe),
    .M_memse(M_memse), .M_memop(M_memop),
    .M_A3(M_A3), .M_regwdop(M_regwdop),
    .M_rt(M_rt), .M_pc(M_pc), .M_Tnew(M_Tnew),
    .M_fwd(M_fwd), .W_regwd(W_regwd),
    .W_regwe(W_regwe), .W_A3(W_A3),
    .W_pc(W_pc), .W_Tnew(W_Tnew)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdl_word(input logic [31:0] a);
    int i;
    i = int'((a >> 2) & 32'hFFF);
    return (i < 3072) ? mdl[i] : 32'd0;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] a,
                                           input logic [2:0] op);
    logic [31:0] w, h, b;
    w = mdl_word(a);
    h = (w >> (16 * ((a >> 1) & 1))) & 32'hFFFF;
    b = (w >> (8 * (a & 3))) & 32'hFF;
    case (op)
      3'd1: return h;
      3'd2: return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'd3: return b;
      3'd4: return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      default: return w;
    endcase
  endfunction

  task automatic mdl_store(input logic [31:0] a, input logic [2:0] op,
                           input logic [31:0] d);
    int i;
    int sh;
    logic [31:0] m;
    i = int'((a >> 2) & 32'hFFF);
    if (i >= 3072) return;
    if (op == 3'd1 || op == 3'd2) begin
      sh = 16 * int'((a >> 1) & 1);
      m = 32'hFFFF << sh;
      mdl[i] = (mdl[i] & ~m) | ((d & 32'hFFFF) << sh);
    end else if (op == 3'd3 || op == 3'd4) begin
      sh = 8 * int'(a & 3);
      m = 32'hFF << sh;
      mdl[i] = (mdl[i] & ~m) | ((d & 32'hFF) << sh);
    end else begin
      mdl[i] = d;
    end
  endtask

  // Drive one M instruction, predict W, advance one edge, update model
  task automatic apply(input logic rst, input logic [2:0] op,
                       input logic [1:0] wdop, input logic [4:0] a3,
                       input logic we, input logic se,
                       input logic [31:0] res, input logic [31:0] rt,
                       input logic [31:0] pc, input logic [1:0] tn);
    reset = rst; M_memop = op; M_regwdop = wdop; M_A3 = a3;
    M_regwe = we; M_memse = se; M_result = res; M_rt = rt;
    M_pc = pc; M_Tnew = tn;
    exp_fwd = (wdop == 2'd0) ? res : (wdop == 2'd2) ? pc + 32'd8 : 32'd0;
    if (rst) begin
      exp_wd = 0; exp_we = 0; exp_a3 = 0; exp_pc = 0; exp_tn = 0;
    end else begin
      case (wdop)
        2'd0: exp_wd = res;
        2'd1: exp_wd = mdl_load(res, op);
        2'd2: exp_wd = pc + 32'd8;
        default: exp_wd = 32'd0;
      endcase
      exp_we = we && (a3 != 0);
      exp_a3 = a3;
      exp_pc = pc;
      exp_tn = (tn > 0) ? tn - 2'd1 : 2'd0;
    end
    #1;
    obs_fwd = M_fwd;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 3072; i++) mdl[i] = 32'd0;
    end else if (se) begin
      mdl_store(res, op, rt);
    end
  endtask

  task automatic test_reset();
    apply(1, 0, 0, 5'd7, 1, 0, 32'h55, 0, 32'h100, 2'd2);
    apply(1, 0, 0, 5'd7, 1, 0, 32'h55, 0, 32'h100, 2'd2);
    n_chk++; if (W_regwd !== 32'd0) begin n_fail++;
      $display("FAIL rst_wd got %h want 0", W_regwd); end
    n_chk++; if (W_regwe !== 1'b0) begin n_fail++;
      $display("FAIL rst_we got %b want 0", W_regwe); end
    n_chk++; if (W_A3 !== 5'd0) begin n_fail++;
      $display("FAIL rst_a3 got %0d want 0", W_A3); end
    n_chk++; if (W_pc !== 32'd0) begin n_fail++;
      $display("FAIL rst_pc got %h want 0", W_pc); end
    n_chk++; if (W_Tnew !== 2'd0) begin n_fail++;
      $display("FAIL rst_tnew got %0d want 0", W_Tnew); end
    apply(0, 0, 1, 5'd5, 1, 0, 32'h0, 0, 32'h200, 2'd0);
    n_chk++; if (W_regwd !== 32'd0 || W_regwe !== 1'b1) begin n_fail++;
      $display("FAIL lw0 got %h/%b want 0/1", W_regwd, W_regwe); end
    apply(0, 0, 1, 5'd5, 0, 0, 32'h2FFC, 0, 32'h204, 2'd0);
    n_chk++; if (W_regwd !== 32'd0 || W_regwe !== 1'b0
                 || W_Tnew !== 2'd0) begin n_fail++;
      $display("FAIL lwtop got %h/%b/%0d want 0/0/0",
               W_regwd, W_regwe, W_Tnew); end
  endtask

  task automatic test_word();
    apply(0, 0, 0, 5'd0, 0, 1, 32'h10, 32'h12345678, 32'h400, 2'd0);
    apply(0, 0, 1, 5'd8, 1, 0, 32'h10, 0, 32'h404, 2'd1);
    n_chk++; if (W_regwd !== 32'h12345678 || W_A3 !== 5'd8) begin
      n_fail++;
      $display("FAIL lw_sw got %h a3=%0d want 12345678 a3=8",
               W_regwd, W_A3); end
    n_chk++; if (W_pc !== 32'h404) begin n_fail++;
      $display("FAIL w_pc got %h want 00000404", W_pc); end
  endtask

  task automatic test_bytes();
    apply(0, 0, 0, 5'd0, 0, 1, 32'h10, 32'h0, 32'h500, 2'd0);
    apply(0, 3, 0, 5'd0, 0, 1, 32'h13, 32'hAB, 32'h504, 2'd0);
    apply(0, 0, 1, 5'd9, 1, 0, 32'h10, 0, 32'h508, 2'd1);
    n_chk++; if (W_regwd !== 32'hAB000000) begin n_fail++;
      $display("FAIL sb_word got %h want ab000000", W_regwd); end
    apply(0, 4, 1, 5'd9, 1, 0, 32'h13, 0, 32'h50C, 2'd1);
    n_chk++; if (W_regwd !== 32'hFFFFFFAB) begin n_fail++;
      $display("FAIL lb got %h want ffffffab", W_regwd); end
    apply(0, 3, 1, 5'd9, 1, 0, 32'h13, 0, 32'h510, 2'd1);
    n_chk++; if (W_regwd !== 32'h000000AB) begin n_fail++;
      $display("FAIL lbu got %h want 000000ab", W_regwd); end
    apply(0, 0, 0, 5'd0, 0, 1, 32'h10, 32'h0, 32'h514, 2'd0);
    apply(0, 1, 0, 5'd0, 0, 1, 32'h12, 32'h8001, 32'h518, 2'd0);
    apply(0, 0, 1, 5'd9, 1, 0, 32'h10, 0, 32'h51C, 2'd1);
    n_chk++; if (W_regwd !== 32'h80010000) begin n_fail++;
      $display("FAIL sh_word got %h want 80010000", W_regwd); end
    apply(0, 2, 1, 5'd9, 1, 0, 32'h12, 0, 32'h520, 2'd1);
    n_chk++; if (W_regwd !== 32'hFFFF8001) begin n_fail++;
      $display("FAIL lh got %h want ffff8001", W_regwd); end
    apply(0, 1, 1, 5'd9, 1, 0, 32'h12, 0, 32'h524, 2'd1);
    n_chk++; if (W_regwd !== 32'h00008001) begin n_fail++;
      $display("FAIL lhu got %h want 00008001", W_regwd); end
  endtask

  task automatic test_jal();
    apply(0, 0, 2, 5'd31, 1, 0, 32'h77, 0, 32'h3000, 2'd0);
    n_chk++; if (obs_fwd !== 32'h3008) begin n_fail++;
      $display("FAIL jal_fwd got %h want 00003008", obs_fwd); end
    n_chk++; if (W_regwd !== 32'h3008 || W_A3 !== 5'd31) begin
      n_fail++;
      $display("FAIL jal_wd got %h want 00003008", W_regwd); end
    apply(0, 0, 2, 5'd31, 1, 0, 0, 0, 32'hFFFFFFFC, 2'd0);
    n_chk++; if (obs_fwd !== 32'h4 || W_regwd !== 32'h4) begin
      n_fail++;
      $display("FAIL pc8_wrap got %h/%h want 4", obs_fwd, W_regwd); end
    apply(0, 0, 1, 5'd3, 1, 0, 32'h10, 0, 32'h600, 2'd1);
    n_chk++; if (obs_fwd !== 32'd0) begin n_fail++;
      $display("FAIL fwd_mem got %h want 0", obs_fwd); end
    apply(0, 0, 3, 5'd3, 1, 0, 32'h99, 0, 32'h604, 2'd0);
    n_chk++; if (obs_fwd !== 32'd0 || W_regwd !== 32'd0) begin
      n_fail++;
      $display("FAIL wd3 got %h/%h want 0", obs_fwd, W_regwd); end
  endtask

  task automatic test_reg0_tnew();
    apply(0, 0, 0, 5'd0, 1, 0, 32'h1, 0, 32'h700, 2'd2);
    n_chk++; if (W_regwe !== 1'b0) begin n_fail++;
      $display("FAIL r0_we got %b want 0", W_regwe); end
    n_chk++; if (W_Tnew !== 2'd1) begin n_fail++;
      $display("FAIL tnew2 got %0d want 1", W_Tnew); end
    apply(0, 0, 0, 5'd4, 1, 0, 32'h1, 0, 32'h704, 2'd0);
    n_chk++; if (W_Tnew !== 2'd0 || W_regwe !== 1'b1) begin n_fail++;
      $display("FAIL tnew0 got %0d/%b want 0/1", W_Tnew, W_regwe); end
    apply(0, 0, 0, 5'd4, 1, 0, 32'h1, 0, 32'h708, 2'd3);
    n_chk++; if (W_Tnew !== 2'd2) begin n_fail++;
      $display("FAIL tnew3 got %0d want 2", W_Tnew); end
  endtask

  task automatic test_oob();
    apply(0, 0, 0, 5'd0, 0, 1, 32'h3000, 32'hDEADBEEF, 32'h800, 2'd0);
    apply(0, 0, 1, 5'd6, 1, 0, 32'h3000, 0, 32'h804, 2'd1);
    n_chk++; if (W_regwd !== 32'd0) begin n_fail++;
      $display("FAIL oob_lw got %h want 0", W_regwd); end
    apply(0, 0, 1, 5'd6, 1, 0, 32'h0, 0, 32'h808, 2'd1);
    n_chk++; if (W_regwd !== 32'd0) begin n_fail++;
      $display("FAIL oob_alias got %h want 0", W_regwd); end
  endtask

  task automatic test_same_cycle();
    apply(0, 0, 0, 5'd0, 0, 1, 32'h40, 32'h11112222, 32'h900, 2'd0);
    apply(0, 0, 1, 5'd2, 1, 1, 32'h40, 32'h33334444, 32'h904, 2'd1);
    n_chk++; if (W_regwd !== 32'h11112222) begin n_fail++;
      $display("FAIL rd_pre got %h want 11112222", W_regwd); end
    apply(0, 0, 1, 5'd2, 1, 0, 32'h40, 0, 32'h908, 2'd1);
    n_chk++; if (W_regwd !== 32'h33334444) begin n_fail++;
      $display("FAIL rd_post got %h want 33334444", W_regwd); end
  endtask

  task automatic test_reset_store();
    apply(0, 0, 0, 5'd0, 0, 1, 32'h20, 32'hCAFEF00D, 32'hA00, 2'd0);
    apply(1, 0, 0, 5'd0, 0, 1, 32'h24, 32'h0BADBEEF, 32'hA04, 2'd0);
    apply(0, 0, 1, 5'd7, 1, 0, 32'h24, 0, 32'hA08, 2'd1);
    n_chk++; if (W_regwd !== 32'd0) begin n_fail++;
      $display("FAIL rst_sw got %h want 0", W_regwd); end
    apply(0, 0, 1, 5'd7, 1, 0, 32'h20, 0, 32'hA0C, 2'd1);
    n_chk++; if (W_regwd !== 32'd0) begin n_fail++;
      $display("FAIL rst_clr got %h want 0", W_regwd); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, pc;
    logic [2:0]  op;
    logic [1:0]  wdop, tn;
    logic        se, we;
    logic [4:0]  a3;
    for (int k = 0; k < 400; k++) begin
      a    = $urandom_range(0, 32'h0FF) + (($urandom_range(0, 3) == 0)
             ? 32'h2F00 : 32'h0);
      if ($urandom_range(0, 15) == 0) a = 32'h3000 + $urandom_range(0, 32'hFFF);
      d    = $urandom;
      pc   = $urandom;
      op   = 3'($urandom_range(0, 7));
      wdop = 2'($urandom_range(0, 3));
      tn   = 2'($urandom_range(0, 3));
      se   = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      a3   = 5'($urandom_range(0, 31));
      apply(0, op, wdop, a3, we, se, a, d, pc, tn);
      n_chk++;
      if (W_regwd !== exp_wd || W_regwe !== exp_we || W_A3 !== exp_a3
          || W_pc !== exp_pc || W_Tnew !== exp_tn
          || obs_fwd !== exp_fwd) begin
        n_fail++;
        $display("FAIL rand%0d got wd=%h we=%b a3=%0d pc=%h tn=%0d fwd=%h want wd=%h we=%b a3=%0d pc=%h tn=%0d fwd=%h",
                 k, W_regwd, W_regwe, W_A3, W_pc, W_Tnew, obs_fwd,
                 exp_wd, exp_we, exp_a3, exp_pc, exp_tn, exp_fwd);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3072; i++) mdl[i] = 32'd0;
    test_reset();
    test_word();
    test_bytes();
    test_jal();
    test_reg0_tnew();
    test_oob();
    test_same_cycle();
    test_reset_store();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
